// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and default widths for the execute-stage shift skid buffer
package ex_pkg;

  localparam int EX_DATA_W = 16;
  localparam int EX_AMT_W  = 4;
  localparam int EX_TAG_W  = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

  typedef struct packed {
    logic [EX_DATA_W-1:0] data;
    logic [EX_AMT_W-1:0]  amt;
    logic                 shift_rotate;
    logic                 left_right;
    logic [EX_TAG_W-1:0]  tag;
    logic                 wb_en;
  } shift_beat_t;

  function automatic logic [1:0] occ_of(input skid_state_t s);
    case (s)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/ex_shift_skid_skid_reg.sv
// rtl/ex_shift_skid_skid_reg.sv - enable-loaded, async-reset beat register (main and skid slots)
module skid_reg
  import ex_pkg::*;
#(
  parameter type T = shift_beat_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  input  T     i_d,
  output T     o_q
);

  T r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_shift_skid.sv
// rtl/ex_shift_skid.sv - two-entry registered skid buffer feeding the execute-stage shifter
// Optional synchronous squash port enabled by EX_SKID_FLUSH_EN.
module ex_shift_skid
  import ex_pkg::*;
#(
  parameter int DATA_W = EX_DATA_W,
  parameter int AMT_W  = EX_AMT_W,
  parameter int TAG_W  = EX_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [AMT_W-1:0]  in_amt,
  input  logic              in_shift_rotate,
  input  logic              in_left_right,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_wb_en,
`ifdef EX_SKID_FLUSH_EN
  input  logic              flush,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [AMT_W-1:0]  out_amt,
  output logic              out_shift_rotate,
  output logic              out_left_right,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_wb_en,
  output logic [1:0]        occ
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              shift_rotate;
    logic              left_right;
    logic [TAG_W-1:0]  tag;
    logic              wb_en;
  } beat_t;

  skid_state_t r_state;
  skid_state_t w_next;
  logic        w_in_beat;
  logic        w_out_beat;
  logic        w_flush;
  logic        w_load_main;
  logic        w_load_skid;
  logic        w_main_from_skid;
  beat_t       w_in_d;
  beat_t       w_main_d;
  beat_t       w_main_q;
  beat_t       w_skid_q;

`ifdef EX_SKID_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // in_ready comes straight from the state register: no path from out_ready.
  assign in_ready   = (r_state != TWO);
  assign out_valid  = (r_state != EMPTY);
  assign occ        = occ_of(r_state);
  assign w_in_beat  = in_valid & in_ready;
  assign w_out_beat = out_valid & out_ready;

  assign w_in_d = '{data: in_data, amt: in_amt, shift_rotate: in_shift_rotate,
                    left_right: in_left_right, tag: in_tag, wb_en: in_wb_en};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next           = r_state;
    w_load_main      = 1'b0;
    w_load_skid      = 1'b0;
    w_main_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_beat) begin
          w_load_main = 1'b1;
          w_next      = ONE;
        end
      end
      ONE: begin
        if (w_in_beat && w_out_beat) begin
          w_load_main = 1'b1;
        end else if (w_out_beat) begin
          w_next = EMPTY;
        end else if (w_in_beat) begin
          w_load_skid = 1'b1;
          w_next      = TWO;
        end
      end
      TWO: begin
        if (w_out_beat) begin
          w_load_main      = 1'b1;
          w_main_from_skid = 1'b1;
          w_next           = ONE;
        end
      end
      default: w_next = EMPTY;
    endcase
    // Squash wins over every handshake; held payload is left as-is.
    if (w_flush) begin
      w_next      = EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
    end
  end

  assign w_main_d = w_main_from_skid ? w_skid_q : w_in_d;

  skid_reg #(.T(beat_t)) u_main (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_load_main),
    .i_d  (w_main_d),
    .o_q  (w_main_q)
  );

  skid_reg #(.T(beat_t)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .i_en (w_load_skid),
    .i_d  (w_in_d),
    .o_q  (w_skid_q)
  );

  assign out_data         = w_main_q.data;
  assign out_amt          = w_main_q.amt;
  assign out_shift_rotate = w_main_q.shift_rotate;
  assign out_left_right   = w_main_q.left_right;
  assign out_tag          = w_main_q.tag;
  assign out_wb_en        = w_main_q.wb_en;

endmodule

// File: tb/tb_ex_shift_skid.sv
// tb/tb_ex_shift_skid.sv - directed self-checking bench for ex_shift_skid
module tb_ex_shift_skid;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        in_shift_rotate;
  logic        in_left_right;
  logic [2:0]  in_tag;
  logic        in_wb_en;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [3:0]  out_amt;
  logic        out_shift_rotate;
  logic        out_left_right;
  logic [2:0]  out_tag;
  logic        out_wb_en;
  logic [1:0]  occ;

  int checks = 0;
  int errors = 0;

  ex_shift_skid dut (
    .clk              (clk),
    .rst              (rst),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_data          (in_data),
    .in_amt           (in_amt),
    .in_shift_rotate  (in_shift_rotate),
    .in_left_right    (in_left_right),
    .in_tag           (in_tag),
    .in_wb_en         (in_wb_en),
`ifdef EX_SKID_FLUSH_EN
    .flush            (flush),
`endif
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_amt          (out_amt),
    .out_shift_rotate (out_shift_rotate),
    .out_left_right   (out_left_right),
    .out_tag          (out_tag),
    .out_wb_en        (out_wb_en),
    .occ              (occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [15:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  // Head must hold while stalled; sampled on the falling edge.
  logic        r_prev_stall = 1'b0;
  logic [15:0] r_prev_data  = '0;
  always @(negedge clk) begin
    if (r_prev_stall && out_valid && !rst)
      check("stall_hold", 32'(out_data), 32'(r_prev_data));
    r_prev_stall = out_valid & ~out_ready & ~rst;
    r_prev_data  = out_data;
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_amt = '0; in_shift_rotate = 1'b1;
    in_left_right = 1'b0; in_tag = '0; in_wb_en = 1'b0;
    flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_occ",   32'(occ), 32'd0);
    check("rst_data",  32'(out_data), 32'd0);

    // streaming, one per cycle
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 16'(1 << i));
      in_amt = 4'(i);
      step();
      check("str_valid", 32'(out_valid), 32'd1);
      check("str_data",  32'(out_data), 32'(1 << i));
      check("str_amt",   32'(out_amt), 32'(i));
      check("str_occ",   32'(occ), 32'd1);
    end
    drive(1'b0, 16'h0);
    step();
    check("str_drain_valid", 32'(out_valid), 32'd0);
    check("str_drain_occ",   32'(occ), 32'd0);

    // back-pressure
    out_ready = 1'b0;
    drive(1'b1, 16'hAAAA); step();
    check("bp_a_data", 32'(out_data), 32'hAAAA);
    check("bp_a_occ",  32'(occ), 32'd1);
    check("bp_a_rdy",  32'(in_ready), 32'd1);
    drive(1'b1, 16'hBBBB); step();
    check("bp_b_data", 32'(out_data), 32'hAAAA);
    check("bp_b_occ",  32'(occ), 32'd2);
    check("bp_b_rdy",  32'(in_ready), 32'd0);
    drive(1'b1, 16'hCCCC); step();
    check("bp_c_data", 32'(out_data), 32'hAAAA);
    check("bp_c_occ",  32'(occ), 32'd2);
    out_ready = 1'b1; step();
    check("bp_out_b",  32'(out_data), 32'hBBBB);
    check("bp_out_b_occ", 32'(occ), 32'd1);
    step();
    check("bp_out_c",  32'(out_data), 32'hCCCC);
    check("bp_out_c_occ", 32'(occ), 32'd1);
    drive(1'b0, 16'h0); step();
    check("bp_drain", 32'(out_valid), 32'd0);

    // simultaneous in/out in ONE
    out_ready = 1'b0;
    drive(1'b1, 16'h00FF); step();
    check("sim_head", 32'(out_data), 32'h00FF);
    out_ready = 1'b1;
    drive(1'b1, 16'hFF00); step();
    check("sim_data", 32'(out_data), 32'hFF00);
    check("sim_occ",  32'(occ), 32'd1);
    drive(1'b0, 16'h0); step();
    check("sim_drain", 32'(occ), 32'd0);

    // field integrity
    out_ready = 1'b0;
    drive(1'b1, 16'h5A5A);
    in_amt = 4'd15; in_shift_rotate = 1'b0; in_left_right = 1'b1;
    in_tag = 3'd7; in_wb_en = 1'b1;
    step();
    check("fld_data", 32'(out_data), 32'h5A5A);
    check("fld_amt",  32'(out_amt), 32'd15);
    check("fld_sr",   32'(out_shift_rotate), 32'd0);
    check("fld_lr",   32'(out_left_right), 32'd1);
    check("fld_tag",  32'(out_tag), 32'd7);
    check("fld_wb",   32'(out_wb_en), 32'd1);
    drive(1'b0, 16'h0);
    in_amt = 4'd0; in_shift_rotate = 1'b1; in_left_right = 1'b0;
    in_tag = 3'd0; in_wb_en = 1'b0;
    out_ready = 1'b1; step();
    check("fld_empty", 32'(out_valid), 32'd0);
    check("fld_hold_amt", 32'(out_amt), 32'd15);
    check("fld_hold_tag", 32'(out_tag), 32'd7);

`ifdef EX_SKID_FLUSH_EN
    out_ready = 1'b0;
    drive(1'b1, 16'h1111); step();
    drive(1'b1, 16'h2222); step();
    check("fl_two", 32'(occ), 32'd2);
    flush = 1'b1;
    drive(1'b1, 16'hCAFE); step();
    flush = 1'b0;
    drive(1'b0, 16'h0);
    check("fl_valid", 32'(out_valid), 32'd0);
    check("fl_ready", 32'(in_ready), 32'd1);
    check("fl_occ",   32'(occ), 32'd0);
    check("fl_data",  32'(out_data), 32'h1111);
    step();
    check("fl_still_empty", 32'(out_valid), 32'd0);
`endif

    // reset mid-stream while holding two beats
    out_ready = 1'b0;
    drive(1'b1, 16'h1234); step();
    drive(1'b1, 16'h5678); step();
    check("mr_two", 32'(occ), 32'd2);
    check("mr_head", 32'(out_data), 32'h1234);
    #2 rst = 1'b1;
    #1;
    check("mr_valid", 32'(out_valid), 32'd0);
    check("mr_ready", 32'(in_ready), 32'd1);
    check("mr_occ",   32'(occ), 32'd0);
    check("mr_data",  32'(out_data), 32'd0);
    drive(1'b0, 16'h0);
    step();
    rst = 1'b0;
    step();
    check("mr_after", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_shift_skid.md
# ex_shift_skid

Two-entry registered skid buffer between decode and the execute-stage shifter. It carries one shift operation per beat: operand, amount, shift/rotate, direction and writeback tag. Valid/ready handshakes on both sides let execute back-pressure decode without dropping operations, and the registered `in_ready` avoids a combinational path from execute back to decode. Its output fields drive the shifter's `In`, `ShAmt`, `shift_rotate` and `left_right` inputs directly.

## Interface
- `DATA_W`, 16, operand width
- `AMT_W`, 4, shift-amount width
- `TAG_W`, 3, destination-register tag width
- `clk`  in  1  clock, all state updates on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  decode presents a beat
- `in_ready`  out  1  buffer accepts a beat this cycle
- `in_data`  in  DATA_W  operand to shift
- `in_amt`  in  AMT_W  shift/rotate amount
- `in_shift_rotate`  in  1  1 = shift, 0 = rotate
- `in_left_right`  in  1  1 = left, 0 = right
- `in_tag`  in  TAG_W  destination register
- `in_wb_en`  in  1  writeback enable
- `flush`  in  1  squash all held beats (present only with `EX_SKID_FLUSH_EN`)
- `out_valid`  out  1  head beat valid
- `out_ready`  in  1  execute consumes the head beat
- `out_data`, `out_amt`, `out_shift_rotate`, `out_left_right`, `out_tag`, `out_wb_en`  out  matching widths  head beat payload
- `occ`  out  2  entries held (0..2)

## Operation
- A beat transfers in when `in_valid & in_ready`, and out when `out_valid & out_ready`.
- Storage: main register (head), skid register, 3-state FSM EMPTY / ONE / TWO.
- Outputs `out_*` come from the main register only. `out_valid = (state != EMPTY)`. `in_ready = (state != TWO)`. `occ` is 0/1/2 per state.
- EMPTY: on in-beat, load main and go to ONE.
- ONE, by case:
  - in-beat and out-beat: load main, stay in ONE.
  - out-beat only: go to EMPTY.
  - in-beat only: load skid, go to TWO.
  - neither: hold.
- TWO: `in_valid` is ignored. On out-beat: main ← skid, go to ONE. Otherwise hold.
- Ordering is strict FIFO. The payload is never modified. Field widths pass through unchanged; no arithmetic is performed.
- Registers are loaded only on accepted beats. Payload registers hold their value while not loading, including when invalid.
- Reset (async, any state): state EMPTY, all payload registers 0, so `out_valid` = 0, `in_ready` = 1, `occ` = 0, all `out_*` fields = 0. Beats in flight at reset are discarded.

## Timing
- Latency is 1 cycle: a beat accepted at edge N is visible on `out_*` after edge N, with `out_valid` = 1 from that cycle.
- Full throughput: one beat per cycle while `out_ready` = 1.
- `in_ready` depends only on registered state. There is no combinational path from `out_ready` to `in_ready`.
- A stall in ONE accepts exactly one more beat into skid. `in_ready` then drops in the next cycle.
- Changing `out_*` while `out_valid & !out_ready` is illegal. The bench asserts the head is stable under stall.

## Configuration
- `EX_SKID_FLUSH_EN` defined: `flush` port exists.
  - Synchronous flush with highest priority: the next state is EMPTY regardless of the handshakes.
  - Any in-beat in the same cycle is dropped. Payload registers are not cleared.
  - `out_valid` = 0 and `in_ready` = 1 in the following cycle.
- `EX_SKID_FLUSH_EN` undefined: no `flush` port, no flush logic. Behaviour is otherwise identical.

## Structure
- Shared package `ex_pkg`:
  - state enum `skid_state_t` {EMPTY, ONE, TWO}
  - packed struct `shift_beat_t` {data, amt, shift_rotate, left_right, tag, wb_en}
  - default width constants 16/4/3
- One natural sub-module `skid_reg`: an enable-loaded, async-reset `shift_beat_t` register, instantiated twice (main and skid).
- The FSM and the handshake logic stay in the top module.

## Test plan
- Reset mid-stream: hold TWO with beats 0x1234 and 0x5678, assert `rst` → `out_valid` = 0, `in_ready` = 1, `occ` = 0, `out_data` = 0 immediately, without waiting for a clock edge.
- Streaming: 8 beats (`in_data` 0x0001..0x0080, `in_amt` 0..7) with `out_ready` = 1 → emerges in order, 1-cycle latency, one per cycle.
- Back-pressure: `out_ready` = 0 while sending A=0xAAAA then B=0xBBBB, then offer C → A held stable, `occ` = 2, `in_ready` = 0, C not accepted. Raise `out_ready` → A, B, C emerge in order.
- Simultaneous in/out in ONE: head 0x00FF with `out_ready` = 1 and `in_valid` = 1 carrying 0xFF00 → next cycle `out_data` = 0xFF00, `occ` = 1.
- Field integrity: beat `amt` = 15, `shift_rotate` = 0, `left_right` = 1, `tag` = 7, `wb_en` = 1 → every `out_*` field matches bit-exactly.
- Flush (`EX_SKID_FLUSH_EN`): in TWO, assert `flush` with `in_valid` = 1 carrying 0xCAFE → next cycle EMPTY, `out_valid` = 0, 0xCAFE never appears on the output.
